clint_timer_arm: RTL and testbench
==================================

CLINT_TIMER_ARM -- requirements
Module: clint_timer_arm

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0200_0000: CLINT base address.
REQ-002 Parameter NR_CORES, default 1: number of harts; HartW = (NR_CORES==1) ? 1 : $clog2(NR_CORES).
REQ-003 Parameter MAX_RETRY, default 3: maximum mtime re-read attempts.
REQ-004 Port clk_i, input, 1: the only clock.
REQ-005 Port rst_i, input, 1: reset, synchronous and active-high.
REQ-006 Port arm_valid_i, input, 1: arm request.
REQ-007 Port arm_ready_o, output, 1: request accepted when arm_valid_i && arm_ready_o.
REQ-008 Port arm_hart_i, input, HartW: target hart, sampled on accept.
REQ-009 Port arm_delta_i, input, 32: ticks from the current mtime, sampled on accept.
REQ-010 Port done_o, output, 1: one-cycle completion pulse.
REQ-011 Port err_o, output, 1: qualified by done_o; retry limit was exceeded.
REQ-012 Port req_o, output, 1: bus request to the CLINT.
REQ-013 Port gnt_i, input, 1: request accepted.
REQ-014 Port we_o, output, 1: write when 1, read when 0.
REQ-015 Port addr_o, output, 32: byte address.
REQ-016 Port be_o, output, 4: byte enables; always 4'hF.
REQ-017 Port wdata_o, output, 32: write data.
REQ-018 Port rvalid_i, input, 1: response valid, for reads and writes.
REQ-019 Port rdata_i, input, 32: read data.

Function
REQ-020 The block SHALL arm the mtimecmp of a hart to mtime+delta over a 32-bit register bus, performing one transaction at a time.
REQ-021 Addresses SHALL be:
- MTIME_LO = BASE+0xBFF8, MTIME_HI = BASE+0xBFFC;
- CMP_LO(h) = BASE+0x4000+8*h, CMP_HI(h) = CMP_LO(h)+4.
REQ-022 Bus handshake rules:
- req_o, we_o, addr_o and wdata_o SHALL stay stable from assertion until the cycle gnt_i=1;
- req_o SHALL deassert the cycle after the grant;
- the next request SHALL NOT issue before rvalid_i of the current transaction;
- rvalid_i arrives at least 1 cycle after the grant.
REQ-023 FSM states: IDLE, RD_HI0, RD_LO, RD_HI1, WR_HMAX, WR_LO, WR_HI, DONE. Each bus state covers issue, grant and response; the FSM advances on rvalid_i.
REQ-024 IDLE: arm_ready_o=1. On accept, latch hart and delta, clear the retry count, and go to RD_HI0.
REQ-025 RD_HI0 SHALL read MTIME_HI into hi0; RD_LO SHALL read MTIME_LO into lo; RD_HI1 SHALL read MTIME_HI into hi1.
REQ-026 After RD_HI1, by case:
- hi1==hi0: target = {hi1,lo} + zero-extended delta, modulo 2^64 (wrap allowed), then go to WR_HMAX;
- hi1!=hi0 and retry<MAX_RETRY: hi0 <= hi1, retry++, return to RD_LO;
- hi1!=hi0 and retry==MAX_RETRY: set error, use {hi1,lo} anyway, go to WR_HMAX.
REQ-027 The write sequence SHALL avoid a spurious interrupt:
- WR_HMAX writes 32'hFFFF_FFFF to CMP_HI;
- WR_LO writes target[31:0] to CMP_LO;
- WR_HI writes target[63:32] to CMP_HI.
REQ-028 DONE SHALL pulse done_o for exactly one cycle, with err_o valid in that cycle, then go to IDLE. done_o and err_o SHALL be 0 at all other times.
REQ-029 arm_ready_o SHALL be 0 in every state except IDLE. A request arriving while busy SHALL be held by the requester and not dropped.
REQ-030 An arm of delta=0 SHALL still perform the full sequence (target = mtime as read).
REQ-031 Best-case latency from accept to done_o, with 1-cycle grant and 1-cycle response, SHALL be 6×2 + 2 = 14 cycles.

Reset
REQ-032 While rst_i=1 at a clk_i edge, the block SHALL enter IDLE.
REQ-033 Outputs during reset SHALL be: req_o=0, we_o=0, addr_o=0, wdata_o=0, be_o=4'hF, done_o=0, err_o=0, arm_ready_o=1 from the first cycle after reset.
REQ-034 Reset mid-transaction SHALL abandon the sequence immediately. No further request is issued, and late gnt_i/rvalid_i SHALL be ignored while in IDLE.

Verification
REQ-035 mtime=0x0000_0001_0000_0010, delta=0x100, hart 0 -> writes, in order:
- CMP_HI=FFFF_FFFF;
- CMP_LO=0000_0110;
- CMP_HI=0000_0001;
- then done_o=1, err_o=0.
REQ-036 Model hi=5, lo=FFFF_FFFF on the first read, then hi=6 on the re-read with lo=2 -> one retry, final CMP_LO=2+delta, CMP_HI=6.
REQ-037 Model where hi changes on every read (MAX_RETRY=3) -> 4 lo reads, done_o with err_o=1, writes still performed.
REQ-038 mtime=FFFF_FFFF_FFFF_FFF0, delta=0x20 -> CMP_LO=0000_0010, CMP_HI=0000_0000 (wrap).
REQ-039 gnt_i delayed 5 cycles and rvalid_i delayed 3 cycles -> request fields stable until grant, no overlapping requests, and a second arm_valid_i is held with arm_ready_o=0.
REQ-040 rst_i asserted while in WR_LO, awaiting grant -> next cycle req_o=0 and arm_ready_o=1, no CMP_HI write follows, and a new arm completes normally.

Source files
------------

// File: rtl/clint_timer_arm.sv
// Arms a hart's mtimecmp to mtime+delta over a 32-bit register bus with one transaction in flight.
// The 64-bit mtime is read hi/lo/hi and retried on carry; mtimecmp is parked at all-ones during the update.
module clint_timer_arm #(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int unsigned NR_CORES  = 1,
  parameter int unsigned MAX_RETRY = 3,
  localparam int unsigned HartW    = (NR_CORES == 1) ? 1 : $clog2(NR_CORES)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              arm_valid_i,
  output logic              arm_ready_o,
  input  logic [HartW-1:0]  arm_hart_i,
  input  logic [31:0]       arm_delta_i,
  output logic              done_o,
  output logic              err_o,
  output logic              req_o,
  input  logic              gnt_i,
  output logic              we_o,
  output logic [31:0]       addr_o,
  output logic [3:0]        be_o,
  output logic [31:0]       wdata_o,
  input  logic              rvalid_i,
  input  logic [31:0]       rdata_i
);

  localparam int unsigned RetryW  = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [31:0] MtimeLo = BASE_ADDR + 32'h0000_BFF8;
  localparam logic [31:0] MtimeHi = BASE_ADDR + 32'h0000_BFFC;
  localparam logic [31:0] CmpBase = BASE_ADDR + 32'h0000_4000;
  localparam logic [31:0] AllOnes = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    S_IDLE, S_RD_HI0, S_RD_LO, S_RD_HI1, S_WR_HMAX, S_WR_LO, S_WR_HI, S_DONE
  } state_t;

  state_t              r_state, w_state;
  logic                r_pend, w_pend;
  logic                r_req, w_req;
  logic                r_we, w_we;
  logic [31:0]         r_addr, w_addr;
  logic [31:0]         r_wdata, w_wdata;
  logic                r_done, w_done;
  logic                r_err_o, w_err_o;
  logic                r_ready, w_ready;
  logic [HartW-1:0]    r_hart, w_hart;
  logic [31:0]         r_delta, w_delta;
  logic [31:0]         r_hi0, w_hi0;
  logic [31:0]         r_lo, w_lo;
  logic [RetryW-1:0]   r_retry, w_retry;
  logic                r_err, w_err;
  logic [63:0]         r_target, w_target;

  logic                w_issue;
  logic                w_iss_we;
  logic [31:0]         w_iss_addr;
  logic [31:0]         w_iss_data;
  logic [31:0]         w_cmp_lo;
  logic [31:0]         w_cmp_hi;
  logic [63:0]         w_sum;

  assign w_cmp_lo = CmpBase + (32'(r_hart) << 3);
  assign w_cmp_hi = w_cmp_lo + 32'd4;
  assign w_sum    = {rdata_i, r_lo} + {32'd0, r_delta};

  // Next-state: each bus state waits for grant, then for the response, then issues the next access.
  always_comb begin
    w_state    = r_state;
    w_pend     = r_pend;
    w_req      = r_req;
    w_we       = r_we;
    w_addr     = r_addr;
    w_wdata    = r_wdata;
    w_done     = 1'b0;
    w_err_o    = 1'b0;
    w_ready    = r_ready;
    w_hart     = r_hart;
    w_delta    = r_delta;
    w_hi0      = r_hi0;
    w_lo       = r_lo;
    w_retry    = r_retry;
    w_err      = r_err;
    w_target   = r_target;
    w_issue    = 1'b0;
    w_iss_we   = 1'b0;
    w_iss_addr = 32'd0;
    w_iss_data = 32'd0;

    case (r_state)
      S_IDLE: begin
        if (arm_valid_i && r_ready) begin
          w_hart     = arm_hart_i;
          w_delta    = arm_delta_i;
          w_retry    = '0;
          w_err      = 1'b0;
          w_ready    = 1'b0;
          w_state    = S_RD_HI0;
          w_issue    = 1'b1;
          w_iss_addr = MtimeHi;
        end
      end
      S_DONE: begin
        w_state = S_IDLE;
        w_ready = 1'b1;
      end
      default: begin
        if (r_req && gnt_i) begin
          w_req  = 1'b0;
          w_pend = 1'b1;
        end else if (r_pend && rvalid_i) begin
          w_pend = 1'b0;
          case (r_state)
            S_RD_HI0: begin
              w_hi0      = rdata_i;
              w_state    = S_RD_LO;
              w_issue    = 1'b1;
              w_iss_addr = MtimeLo;
            end
            S_RD_LO: begin
              w_lo       = rdata_i;
              w_state    = S_RD_HI1;
              w_issue    = 1'b1;
              w_iss_addr = MtimeHi;
            end
            S_RD_HI1: begin
              w_issue = 1'b1;
              if ((rdata_i != r_hi0) && (r_retry < RetryW'(MAX_RETRY))) begin
                w_hi0      = rdata_i;
                w_retry    = r_retry + RetryW'(1);
                w_state    = S_RD_LO;
                w_iss_addr = MtimeLo;
              end else begin
                // An exhausted retry budget still arms, using the last consistent-looking sample.
                w_err      = r_err | (rdata_i != r_hi0);
                w_target   = w_sum;
                w_state    = S_WR_HMAX;
                w_iss_we   = 1'b1;
                w_iss_addr = w_cmp_hi;
                w_iss_data = AllOnes;
              end
            end
            S_WR_HMAX: begin
              w_state    = S_WR_LO;
              w_issue    = 1'b1;
              w_iss_we   = 1'b1;
              w_iss_addr = w_cmp_lo;
              w_iss_data = r_target[31:0];
            end
            S_WR_LO: begin
              w_state    = S_WR_HI;
              w_issue    = 1'b1;
              w_iss_we   = 1'b1;
              w_iss_addr = w_cmp_hi;
              w_iss_data = r_target[63:32];
            end
            S_WR_HI: begin
              w_state = S_DONE;
              w_done  = 1'b1;
              w_err_o = r_err;
            end
            default: ;
          endcase
        end
      end
    endcase

    if (w_issue) begin
      w_req   = 1'b1;
      w_we    = w_iss_we;
      w_addr  = w_iss_addr;
      w_wdata = w_iss_data;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_pend   <= 1'b0;
      r_req    <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= 32'd0;
      r_wdata  <= 32'd0;
      r_done   <= 1'b0;
      r_err_o  <= 1'b0;
      r_ready  <= 1'b1;
      r_hart   <= '0;
      r_delta  <= 32'd0;
      r_hi0    <= 32'd0;
      r_lo     <= 32'd0;
      r_retry  <= '0;
      r_err    <= 1'b0;
      r_target <= 64'd0;
    end else begin
      r_state  <= w_state;
      r_pend   <= w_pend;
      r_req    <= w_req;
      r_we     <= w_we;
      r_addr   <= w_addr;
      r_wdata  <= w_wdata;
      r_done   <= w_done;
      r_err_o  <= w_err_o;
      r_ready  <= w_ready;
      r_hart   <= w_hart;
      r_delta  <= w_delta;
      r_hi0    <= w_hi0;
      r_lo     <= w_lo;
      r_retry  <= w_retry;
      r_err    <= w_err;
      r_target <= w_target;
    end
  end

  assign arm_ready_o = r_ready;
  assign done_o      = r_done;
  assign err_o       = r_err_o;
  assign req_o       = r_req;
  assign we_o        = r_we;
  assign addr_o      = r_addr;
  assign wdata_o     = r_wdata;
  assign be_o        = 4'hF;

endmodule

// File: tb/tb_clint_timer_arm.sv
// Bench for clint_timer_arm: CLINT bus responder with scripted mtime samples, protocol monitor,
// and a reference model of the arm rules (hi/lo/hi sampling with bounded retry, 64-bit wrap).
module tb_clint_timer_arm;

  localparam logic [31:0] BASE  = 32'h0200_0000;
  localparam int unsigned NCORE = 4;
  localparam int unsigned MAXR  = 3;
  localparam int unsigned HW    = 2;
  localparam logic [31:0] A_MTLO = BASE + 32'h0000_BFF8;
  localparam logic [31:0] A_MTHI = BASE + 32'h0000_BFFC;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          arm_valid_i = 1'b0;
  logic          arm_ready_o;
  logic [HW-1:0] arm_hart_i = '0;
  logic [31:0]   arm_delta_i = 32'd0;
  logic          done_o, err_o, req_o, we_o;
  logic          gnt_i = 1'b0;
  logic          rvalid_i = 1'b0;
  logic [31:0]   addr_o, wdata_o, rdata_i = 32'd0;
  logic [3:0]    be_o;

  clint_timer_arm #(.BASE_ADDR(BASE), .NR_CORES(NCORE), .MAX_RETRY(MAXR)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .arm_valid_i(arm_valid_i), .arm_ready_o(arm_ready_o),
    .arm_hart_i(arm_hart_i), .arm_delta_i(arm_delta_i), .done_o(done_o), .err_o(err_o),
    .req_o(req_o), .gnt_i(gnt_i), .we_o(we_o), .addr_o(addr_o), .be_o(be_o),
    .wdata_o(wdata_o), .rvalid_i(rvalid_i), .rdata_i(rdata_i)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;

  // Scripted CLINT: successive MTIME_HI / MTIME_LO reads walk these tables, holding the last entry.
  logic [31:0] hi_seq [16];
  logic [31:0] lo_seq [16];
  int hi_len = 1, lo_len = 1;
  int hi_rd = 0, lo_rd = 0, hi_base = 0, lo_base = 0, wr_base = 0;
  int gnt_dly = 0, rsp_dly = 1;
  int inject_req = 0, inject_done = 0;
  logic [31:0] wr_addr_q [$];
  logic [31:0] wr_data_q [$];

  bit          req_seen = 0, outstanding = 0;
  int          gnt_cnt = 0, rsp_cnt = 0;
  logic [31:0] rsp_data = 32'd0;
  logic        prev_req = 0, prev_gnt = 0, prev_we = 0, prev_done = 0, prev_rst = 1;
  logic [31:0] prev_addr = 32'd0, prev_wdata = 32'd0;
  int          viol = 0;
  int          ready_busy = 0;

  function automatic logic [31:0] hv(input int i);
    if (i >= hi_len) i = hi_len - 1;
    return hi_seq[i];
  endfunction

  function automatic logic [31:0] lv(input int i);
    if (i >= lo_len) i = lo_len - 1;
    return lo_seq[i];
  endfunction

  function automatic logic [31:0] cmp_lo(input int h);
    return BASE + 32'h0000_4000 + 32'(h * 8);
  endfunction

  // Monitor first (values held since the last posedge), then the responder drives for the next edge.
  always @(negedge clk_i) begin
    if (!prev_rst) begin
      if (prev_req && !prev_gnt &&
          (!req_o || we_o !== prev_we || addr_o !== prev_addr || wdata_o !== prev_wdata)) viol++;
      if (prev_req && prev_gnt && req_o) viol++;
      if (req_o && !prev_req && outstanding) viol++;
      if (err_o && !done_o) viol++;
      if (done_o && prev_done) viol++;
      if (be_o !== 4'hF) viol++;
    end
    gnt_i    = 1'b0;
    rvalid_i = 1'b0;
    if (rst_i) begin
      outstanding = 0;
      req_seen    = 0;
    end else if (inject_req != inject_done) begin
      inject_done++;
      gnt_i    = 1'b1;
      rvalid_i = 1'b1;
      rdata_i  = 32'hDEAD_BEEF;
    end else if (outstanding) begin
      if (rsp_cnt == 0) begin
        rvalid_i    = 1'b1;
        rdata_i     = rsp_data;
        outstanding = 0;
      end else rsp_cnt--;
    end else if (req_o) begin
      if (!req_seen) begin
        req_seen = 1;
        gnt_cnt  = gnt_dly;
      end
      if (gnt_cnt == 0) begin
        gnt_i       = 1'b1;
        req_seen    = 0;
        outstanding = 1;
        rsp_cnt     = rsp_dly - 1;
        rsp_data    = 32'd0;
        if (we_o) begin
          wr_addr_q.push_back(addr_o);
          wr_data_q.push_back(wdata_o);
        end else if (addr_o == A_MTHI) begin
          rsp_data = hv(hi_rd - hi_base);
          hi_rd++;
        end else if (addr_o == A_MTLO) begin
          rsp_data = lv(lo_rd - lo_base);
          lo_rd++;
        end
      end else gnt_cnt--;
    end else req_seen = 0;
    prev_req   = req_o;
    prev_gnt   = gnt_i;
    prev_we    = we_o;
    prev_addr  = addr_o;
    prev_wdata = wdata_o;
    prev_done  = done_o;
    prev_rst   = rst_i;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic rebase();
    hi_base = hi_rd;
    lo_base = lo_rd;
    wr_base = wr_addr_q.size();
  endtask

  function automatic logic [63:0] wr_get(input int k);
    int i;
    i = wr_base + k;
    if (i < wr_addr_q.size()) return {wr_addr_q[i], wr_data_q[i]};
    return 'x;
  endfunction

  // Arm rule: sample hi, then lo+hi until hi repeats or MAXR re-reads are spent; target wraps mod 2^64.
  function automatic void ref_model(input logic [31:0] d, output logic [63:0] tgt,
                                    output bit err, output int nlo);
    logic [31:0] hi0, hi1, lo;
    hi0 = hv(0);
    hi1 = hi0;
    lo  = 32'd0;
    err = 0;
    nlo = 0;
    for (int k = 0; k <= int'(MAXR); k++) begin
      lo  = lv(k);
      hi1 = hv(k + 1);
      nlo = k + 1;
      if (hi1 == hi0) break;
      if (k == int'(MAXR)) begin
        err = 1;
        break;
      end
      hi0 = hi1;
    end
    tgt = {hi1, lo} + {32'd0, d};
  endfunction

  task automatic accept(output bit acc);
    acc = 0;
    for (int i = 0; i < 300; i++) begin
      if (arm_ready_o) begin
        tick();
        acc = 1;
        break;
      end
      tick();
    end
    check("accept", 64'(acc), 64'd1);
  endtask

  task automatic wait_done(output bit got, output logic eo, output int lat);
    got = 0;
    eo  = 1'bx;
    lat = 0;
    for (int i = 0; i < 600; i++) begin
      tick();
      lat++;
      if (arm_ready_o) ready_busy++;
      if (done_o) begin
        got = 1;
        eo  = err_o;
        break;
      end
    end
    tick();
    check("done_pulse_width", 64'(done_o), 64'd0);
    check("ready_after_done", 64'(arm_ready_o), 64'd1);
  endtask

  task automatic do_arm(input int h, input logic [31:0] d, output bit got, output logic eo,
                        output int lat);
    bit acc;
    arm_valid_i = 1'b1;
    arm_hart_i  = HW'(h);
    arm_delta_i = d;
    accept(acc);
    arm_valid_i = 1'b0;
    got = 0;
    eo  = 1'bx;
    lat = 0;
    if (acc) wait_done(got, eo, lat);
  endtask

  task automatic verify(input string tag, input int h, input logic [31:0] d, input bit got,
                        input logic eo);
    logic [63:0] tgt;
    bit          e;
    int          nlo;
    ref_model(d, tgt, e, nlo);
    check({tag, ".done"}, 64'(got), 64'd1);
    check({tag, ".err"}, 64'(eo), 64'(e));
    check({tag, ".lo_reads"}, 64'(lo_rd - lo_base), 64'(nlo));
    check({tag, ".nwr"}, 64'(wr_addr_q.size() - wr_base), 64'd3);
    check({tag, ".wr_hmax"}, wr_get(0), {cmp_lo(h) + 32'd4, 32'hFFFF_FFFF});
    check({tag, ".wr_lo"}, wr_get(1), {cmp_lo(h), tgt[31:0]});
    check({tag, ".wr_hi"}, wr_get(2), {cmp_lo(h) + 32'd4, tgt[63:32]});
    check({tag, ".protocol"}, 64'(viol), 64'd0);
    check({tag, ".ready_busy"}, 64'(ready_busy), 64'd0);
  endtask

  initial begin
    bit          got, acc, found;
    logic        eo;
    int          lat, nreq, h, nchg;
    logic [31:0] hb, d;

    for (int i = 0; i < 16; i++) begin
      hi_seq[i] = 32'd0;
      lo_seq[i] = 32'd0;
    end

    // Reset values
    rst_i = 1'b1;
    repeat (3) tick();
    check("rst.req", 64'(req_o), 64'd0);
    check("rst.we", 64'(we_o), 64'd0);
    check("rst.addr", 64'(addr_o), 64'd0);
    check("rst.wdata", 64'(wdata_o), 64'd0);
    check("rst.be", 64'(be_o), 64'hF);
    check("rst.done", 64'(done_o), 64'd0);
    check("rst.err", 64'(err_o), 64'd0);
    check("rst.ready", 64'(arm_ready_o), 64'd1);
    rst_i = 1'b0;
    tick();

    // mtime 1_0000_0010 + 0x100, best-case bus: 14 cycles counting the accept and done cycles
    hi_seq[0] = 32'h1; hi_len = 1;
    lo_seq[0] = 32'h10; lo_len = 1;
    rebase();
    do_arm(0, 32'h100, got, eo, lat);
    verify("basic", 0, 32'h100, got, eo);
    check("basic.latency_edges", 64'(lat), 64'd12);
    check("basic.lo_lit", wr_get(1), {cmp_lo(0), 32'h0000_0110});
    check("basic.hi_lit", wr_get(2), {cmp_lo(0) + 32'd4, 32'h0000_0001});

    // Carry between samples: one retry
    hi_seq[0] = 32'd5; hi_seq[1] = 32'd6; hi_len = 2;
    lo_seq[0] = 32'hFFFF_FFFF; lo_seq[1] = 32'd2; lo_len = 2;
    rebase();
    do_arm(1, 32'h40, got, eo, lat);
    verify("retry1", 1, 32'h40, got, eo);
    check("retry1.lo_lit", wr_get(1), {cmp_lo(1), 32'h42});
    check("retry1.hi_lit", wr_get(2), {cmp_lo(1) + 32'd4, 32'h6});

    // hi changes on every read: retries exhausted, still writes, err flagged
    for (int i = 0; i < 10; i++) begin
      hi_seq[i] = 32'(i + 1);
      lo_seq[i] = 32'h100 + 32'(i);
    end
    hi_len = 10; lo_len = 10;
    rebase();
    do_arm(2, 32'h10, got, eo, lat);
    verify("retryx", 2, 32'h10, got, eo);
    check("retryx.lo_reads_lit", 64'(lo_rd - lo_base), 64'd4);
    check("retryx.err_lit", 64'(eo), 64'd1);

    // 64-bit wrap
    hi_seq[0] = 32'hFFFF_FFFF; hi_len = 1;
    lo_seq[0] = 32'hFFFF_FFF0; lo_len = 1;
    rebase();
    do_arm(3, 32'h20, got, eo, lat);
    verify("wrap", 3, 32'h20, got, eo);
    check("wrap.lo_lit", wr_get(1), {cmp_lo(3), 32'h10});
    check("wrap.hi_lit", wr_get(2), {cmp_lo(3) + 32'd4, 32'h0});

    // Slow bus with a second arm held while busy
    gnt_dly = 5; rsp_dly = 3;
    hi_seq[0] = 32'h0000_0042; lo_seq[0] = 32'h1234_5678;
    rebase();
    arm_valid_i = 1'b1; arm_hart_i = HW'(1); arm_delta_i = 32'h0000_1000;
    accept(acc);
    arm_hart_i = HW'(2); arm_delta_i = 32'hF000_0000;
    check("held.ready_low", 64'(arm_ready_o), 64'd0);
    wait_done(got, eo, lat);
    verify("slowA", 1, 32'h0000_1000, got, eo);
    rebase();
    accept(acc);
    arm_valid_i = 1'b0;
    wait_done(got, eo, lat);
    verify("slowB", 2, 32'hF000_0000, got, eo);

    // Reset while WR_LO awaits grant
    rebase();
    arm_valid_i = 1'b1; arm_hart_i = HW'(2); arm_delta_i = 32'h55;
    accept(acc);
    arm_valid_i = 1'b0;
    found = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (req_o && we_o && addr_o == cmp_lo(2)) begin
        found = 1;
        break;
      end
    end
    check("rstmid.reach_wr_lo", 64'(found), 64'd1);
    rst_i = 1'b1;
    tick();
    check("rstmid.req", 64'(req_o), 64'd0);
    check("rstmid.ready", 64'(arm_ready_o), 64'd1);
    rst_i = 1'b0;
    inject_req++;
    nreq = 0;
    repeat (6) begin
      tick();
      if (req_o) nreq++;
    end
    check("rstmid.no_req", 64'(nreq), 64'd0);
    check("rstmid.writes", 64'(wr_addr_q.size() - wr_base), 64'd1);
    gnt_dly = 0; rsp_dly = 1;
    rebase();
    do_arm(2, 32'h77, got, eo, lat);
    verify("rstmid.rearm", 2, 32'h77, got, eo);

    // Randomized arms: random mtime, carries, delays, harts; first one uses delta 0
    for (int it = 0; it < 10; it++) begin
      gnt_dly = $urandom_range(0, 3);
      rsp_dly = $urandom_range(1, 3);
      hb   = $urandom();
      nchg = $urandom_range(0, 5);
      for (int i = 0; i < 16; i++) begin
        hi_seq[i] = hb + 32'(i);
        lo_seq[i] = $urandom();
      end
      hi_len = nchg + 1;
      lo_len = 16;
      d = (it == 0) ? 32'd0 : $urandom();
      h = $urandom_range(0, 3);
      rebase();
      do_arm(h, d, got, eo, lat);
      verify($sformatf("rnd%0d", it), h, d, got, eo);
    end

    check("final.protocol", 64'(viol), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
